// File: rtl/multi_op_seq.sv
// multi_op_seq: sequential signed arithmetic unit with valid/ready handshakes.
//
// Computes A+B, A-B, A*B or C+A*B on signed operands. The multiply is
// shift-and-add, one partial product per cycle over M cycles, with the MSB of
// B weighted negatively so the result is an exact two's-complement product.
// All results are N+M+2 bits wide.
//
// Optional build macro: MULTI_OP_ACC_EN
//   When defined, an internal accumulator replaces the C port for op 11. The
//   accumulator captures every result on its output handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid, in_ready  input handshake for op/A/B/C
//   op                  00 A+B, 01 A-B, 10 A*B, 11 C+A*B
//   A [N], B [M]        signed operands
//   C [N+M+2]           signed addend (op 11 only)
//   out_valid, out_ready output handshake for Y
//   Y [N+M+2]           signed result, held stable while out_valid is high
//   busy                high in any state other than idle

module multi_op_seq #(
    parameter int unsigned N = 16,
    parameter int unsigned M = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            op,
    input  logic signed [N-1:0]   A,
    input  logic signed [M-1:0]   B,
    input  logic signed [N+M+1:0] C,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [N+M+1:0] Y,
    output logic                  busy
);

    localparam int unsigned W    = N + M + 2;
    localparam int unsigned CntW = (M > 1) ? $clog2(M) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StAddSub,
        StMul,
        StMacAdd,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [N-1:0]        a_q, a_d;
    logic [M-1:0]        b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic signed [W-1:0] prod_q, prod_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic signed [W-1:0] y_q, y_d;
    logic signed [W-1:0] addend;

`ifdef MULTI_OP_ACC_EN
    logic signed [W-1:0] acc_q, acc_d;
`else
    logic signed [W-1:0] c_q, c_d;
`endif

    logic                accept;
    logic                last_iter;
    logic signed [W-1:0] a_ext, b_ext, pp, prod_sum;

    assign accept    = in_valid && (state_q == StIdle);
    assign last_iter = (cnt_q == CntW'(M - 1));

    assign a_ext = {{(W - N){a_q[N-1]}}, a_q};
    assign b_ext = {{(W - M){b_q[M-1]}}, b_q};

    // Bit M-1 of B carries weight -2^(M-1), hence subtract on the last step.
    assign pp       = b_q[cnt_q] ? (a_ext << cnt_q) : '0;
    assign prod_sum = last_iter ? (prod_q - pp) : (prod_q + pp);

`ifdef MULTI_OP_ACC_EN
    assign addend = acc_q;
`else
    assign addend = c_q;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = op[1] ? StMul : StAddSub;
                end
            end
            StAddSub: state_d = StDone;
            StMul: begin
                if (last_iter) begin
                    state_d = op_q[0] ? StMacAdd : StDone;
                end
            end
            StMacAdd: state_d = StDone;
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
    end

    // ---------------- Datapath next state ----------------
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        op_d   = op_q;
        prod_d = prod_q;
        cnt_d  = cnt_q;
        y_d    = y_q;
`ifdef MULTI_OP_ACC_EN
        acc_d  = acc_q;
`else
        c_d    = c_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    a_d  = A;
                    b_d  = B;
                    op_d = op;
`ifndef MULTI_OP_ACC_EN
                    c_d  = C;
`endif
                    if (op[1]) begin
                        prod_d = '0;
                        cnt_d  = '0;
                    end
                end
            end
            StAddSub: begin
                y_d = op_q[0] ? (a_ext - b_ext) : (a_ext + b_ext);
            end
            StMul: begin
                prod_d = prod_sum;
                if (last_iter) begin
                    cnt_d = '0;
                    if (!op_q[0]) begin
                        y_d = prod_sum;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StMacAdd: begin
                // Wraps modulo 2^W by construction.
                y_d = addend + prod_q;
            end
            StDone: begin
`ifdef MULTI_OP_ACC_EN
                if (out_ready) begin
                    acc_d = y_q;
                end
`endif
            end
            default: ;
        endcase
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            prod_q <= '0;
            cnt_q  <= '0;
            y_q    <= '0;
`ifdef MULTI_OP_ACC_EN
            acc_q  <= '0;
`else
            c_q    <= '0;
`endif
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            op_q   <= op_d;
            prod_q <= prod_d;
            cnt_q  <= cnt_d;
            y_q    <= y_d;
`ifdef MULTI_OP_ACC_EN
            acc_q  <= acc_d;
`else
            c_q    <= c_d;
`endif
        end
    end

    assign Y = y_q;

`ifndef MULTI_OP_ACC_EN
    // C is only consumed through its registered copy; keep the port referenced.
`endif

endmodule
